spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

SPI mode-0 receive-only slave that deserialises host bytes into the `clk_in` domain, tagging each byte with the D/C line. It sits directly upstream of the layer/address controller. Every completed byte produces a one-cycle `byte_rdy_out` strobe with `byte_data_out` and `dc_out` stable. All SPI pins are asynchronous to `clk_in` and are oversampled through synchronisers.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of each input synchroniser; legal range 2–4.
- `clk_in` input 1: system clock; all logic on rising edge.
- `rst_n_in` input 1: reset, asynchronous, active-low.
- `spi_sclk_in` input 1: SPI clock, CPOL=0/CPHA=0, data sampled on rising edge.
- `spi_mosi_in` input 1: serial data, MSB first.
- `spi_cs_n_in` input 1: chip select, active-low.
- `spi_dc_in` input 1: data/command select (0 = command, 1 = data).
- `byte_rdy_out` output 1: one-cycle strobe per completed byte.
- `byte_data_out` output 8: last completed byte; held until the next strobe.
- `dc_out` output 1: D/C level captured with the byte; held until the next strobe.
- `err_out` output 1: present only with `SPI_SLAVE_RX_ERR_EN`; one-cycle strobe on an aborted partial byte.

## Operation
- All four SPI inputs pass through identical `SYNC_STAGES` synchronisers, so they stay mutually aligned. One extra register on the synchronised SCLK provides edge detection.
- `sclk_rise` = synchronised SCLK is 1 and its delayed copy is 0.
- State IDLE: synchronised CS_n = 1. `bit_cnt` is held at 0 and the shift register is not written.
- IDLE → ACTIVE when synchronised CS_n = 0.
- State ACTIVE, on `sclk_rise`:
  - `shift <= {shift[6:0], mosi_s}`.
  - `bit_cnt <= bit_cnt + 1`; 3-bit counter, wraps 7 → 0.
  - When `bit_cnt == 7`: register `byte_data_out <= {shift[6:0], mosi_s}`, `dc_out <= dc_s`, and `byte_rdy_out <= 1` for exactly one cycle.
- ACTIVE → IDLE when synchronised CS_n = 1.
  - `bit_cnt` is cleared.
  - A partial byte (`bit_cnt != 0`) is discarded and produces no strobe.
- Priority: CS_n = 1 in a cycle overrides a coincident `sclk_rise`. That edge is ignored.
- Back-to-back bytes within one CS assertion are supported with no gap. `bit_cnt` wraps and continues.
- D/C is sampled only at the 8th edge. Toggling D/C mid-byte has no effect.
- Reset values: `byte_rdy_out` = 0, `byte_data_out` = 8'h00, `dc_out` = 0, `err_out` = 0. Internal state: `bit_cnt` = 0, shift register = 0, synchronisers = 0, state = IDLE.
- Reset asserted mid-byte: all state clears immediately and the partial byte is lost. After release, reception resumes at the next byte boundary, i.e. the host must restart the byte.

## Timing
- Latency: from the 8th SCLK rising edge at the pin to the `byte_rdy_out` high cycle is `SYNC_STAGES` + 2 `clk_in` cycles, ±1 for sampling phase.
- `byte_data_out` and `dc_out` change in the same cycle that `byte_rdy_out` rises.
- Input constraints (each ≥ 2 `clk_in` periods):
  - SCLK high time and SCLK low time.
  - MOSI and DC setup and hold around SCLK rise.
  - CS_n high time between transactions.
  - In practice: f_clk ≥ 4 × f_sclk.
- `byte_rdy_out` never asserts on two consecutive cycles.
- No backpressure: the consumer must accept each strobe.

## Configuration
- `SPI_SLAVE_RX_ERR_EN` defined:
  - The `err_out` port exists.
  - `err_out` pulses for one cycle on ACTIVE → IDLE with `bit_cnt != 0`, in the same cycle `bit_cnt` clears.
- Not defined:
  - No port and no logic.
  - A partial byte is silently discarded.

## Structure
- Shared package `cube0414_pkg` holds:
  - Command codes: `CUBE0414_ADDR_WR` = 8'hcc, `CUBE0414_DATA_WR` = 8'hda.
  - `SPI_BITS_PER_BYTE` = 8.
  - The state encoding (IDLE/ACTIVE).
- One sub-module, `input_sync`: a parameterised `SYNC_STAGES`-deep single-bit synchroniser with asynchronous reset to 0, instantiated four times.

## Test plan
- Single byte 8'hcc with DC = 0, f_sclk = clk/8 → exactly one strobe; `byte_data_out` = 8'hcc, `dc_out` = 0; latency within `SYNC_STAGES` + 2 ±1 cycles of the 8th edge.
- One CS assertion carrying 8'hda (DC = 0) then 192 data bytes 8'h00..8'hbf (DC = 1) at f_sclk = clk/4 → 193 strobes in order with correct values and DC.
- CS deasserted after 5 bits of 8'hff, then full byte 8'h5a → single strobe with 8'h5a; with `SPI_SLAVE_RX_ERR_EN`, one `err_out` pulse at the abort.
- DC toggled 0 → 1 → 0 during bits 2–6, DC = 1 at bit 8 → `dc_out` = 1.
- `rst_n_in` pulsed low after bit 4 of 8'hab, then 8'h3c sent in a fresh CS assertion → outputs read 0 during reset, then one strobe with 8'h3c.
- CS_n rise coincident with the synchronised 8th SCLK edge → no strobe, `bit_cnt` = 0.

Source files
------------

// File: rtl/cube0414_pkg.sv
// -----------------------------------------------------------------------------
// cube0414_pkg
//   Definitions shared by the SPI receive front end and the layer/address
//   controller that consumes its bytes.
//
//   Contents:
//     CUBE0414_ADDR_WR / CUBE0414_DATA_WR : host command codes
//     SPI_BITS_PER_BYTE                   : bits per SPI byte
//     SPI_BIT_CNT_W                       : width of the bit counter
//     rx_state_e                          : receiver state encoding
//     rx_byte_t                           : received byte plus its D/C tag
// -----------------------------------------------------------------------------
package cube0414_pkg;

  // Host command codes, sent with D/C = 0.
  localparam logic [7:0] CUBE0414_ADDR_WR = 8'hcc;
  localparam logic [7:0] CUBE0414_DATA_WR = 8'hda;

  localparam int SPI_BITS_PER_BYTE = 8;
  localparam int SPI_BIT_CNT_W     = $clog2(SPI_BITS_PER_BYTE);

  // IDLE while chip select is high, ACTIVE while it is low.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } rx_state_e;

  // One received byte together with the D/C level captured at its last bit.
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } rx_byte_t;

endpackage : cube0414_pkg

// File: rtl/spi_slave_rx_if.sv
// -----------------------------------------------------------------------------
// spi_slave_rx_if
//   Bundles the SPI pins seen by the receiver and the byte-strobe interface it
//   presents to the downstream controller.
//
//   Signals:
//     spi_sclk_in   : SPI clock (mode 0), asynchronous to the system clock
//     spi_mosi_in   : serial data, MSB first
//     spi_cs_n_in   : chip select, active-low
//     spi_dc_in     : data/command select (0 = command, 1 = data)
//     byte_rdy_out  : one-cycle strobe per completed byte
//     byte_data_out : last completed byte, held until the next strobe
//     dc_out        : D/C level captured with the byte
//     err_out       : aborted-partial-byte strobe (SPI_SLAVE_RX_ERR_EN only)
//
//   Modports:
//     master : the host side / test driver (drives SPI pins, reads bytes)
//     slave  : the receiver (reads SPI pins, drives the byte interface)
// -----------------------------------------------------------------------------
interface spi_slave_rx_if;

  logic       spi_sclk_in;
  logic       spi_mosi_in;
  logic       spi_cs_n_in;
  logic       spi_dc_in;
  logic       byte_rdy_out;
  logic [7:0] byte_data_out;
  logic       dc_out;
`ifdef SPI_SLAVE_RX_ERR_EN
  logic       err_out;
`endif

`ifdef SPI_SLAVE_RX_ERR_EN
  modport master (
    output spi_sclk_in, spi_mosi_in, spi_cs_n_in, spi_dc_in,
    input  byte_rdy_out, byte_data_out, dc_out, err_out
  );

  modport slave (
    input  spi_sclk_in, spi_mosi_in, spi_cs_n_in, spi_dc_in,
    output byte_rdy_out, byte_data_out, dc_out, err_out
  );
`else
  modport master (
    output spi_sclk_in, spi_mosi_in, spi_cs_n_in, spi_dc_in,
    input  byte_rdy_out, byte_data_out, dc_out
  );

  modport slave (
    input  spi_sclk_in, spi_mosi_in, spi_cs_n_in, spi_dc_in,
    output byte_rdy_out, byte_data_out, dc_out
  );
`endif

endinterface : spi_slave_rx_if

// File: rtl/spi_slave_rx_input_sync.sv
// -----------------------------------------------------------------------------
// input_sync
//   SYNC_STAGES-deep single-bit synchroniser bringing an asynchronous pin into
//   the clk_in domain. All flops reset to 0.
//
//   Ports:
//     clk_in   : system clock
//     rst_n_in : asynchronous active-low reset
//     d        : asynchronous input
//     q        : synchronised output, SYNC_STAGES cycles behind d
// -----------------------------------------------------------------------------
module input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      stages <= '0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule : input_sync

// File: rtl/spi_slave_rx.sv
// -----------------------------------------------------------------------------
// spi_slave_rx
//   SPI mode-0 receive-only slave. Oversamples SCLK/MOSI/CS_n/DC through
//   identical synchronisers, detects SCLK rising edges in the clk_in domain,
//   shifts MOSI in MSB first and emits one byte_rdy_out strobe per completed
//   byte together with the D/C level sampled on the byte's 8th edge.
//
//   Parameters:
//     SYNC_STAGES : synchroniser depth, legal range 2..4
//
//   Ports:
//     clk_in   : system clock, rising edge
//     rst_n_in : asynchronous active-low reset
//     bus      : spi_slave_rx_if.slave (SPI pins in, byte interface out)
//
//   Build option:
//     SPI_SLAVE_RX_ERR_EN : when defined, bus.err_out pulses for one cycle
//                           when chip select is released in the middle of a
//                           byte. When undefined the partial byte is dropped
//                           silently and err_out does not exist.
//
//   Latency from the 8th SCLK rise at the pin to byte_rdy_out is about
//   SYNC_STAGES + 1..2 clk_in cycles depending on sampling phase.
// -----------------------------------------------------------------------------
module spi_slave_rx
  import cube0414_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  spi_slave_rx_if.slave bus
);

  localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(SPI_BITS_PER_BYTE - 1);

  // ---------------------------------------------------------------------------
  // Synchronisers: all four pins share the same depth so their relative
  // timing is preserved in the clk_in domain.
  // ---------------------------------------------------------------------------
  logic sclk_s;
  logic mosi_s;
  logic cs_n_s;
  logic dc_s;

  input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (bus.spi_sclk_in),
    .q        (sclk_s)
  );

  input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (bus.spi_mosi_in),
    .q        (mosi_s)
  );

  input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs_n (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (bus.spi_cs_n_in),
    .q        (cs_n_s)
  );

  input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dc (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (bus.spi_dc_in),
    .q        (dc_s)
  );

  // ---------------------------------------------------------------------------
  // SCLK edge detection
  // ---------------------------------------------------------------------------
  logic sclk_d;
  logic sclk_rise;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sclk_d <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;

  // ---------------------------------------------------------------------------
  // Receive FSM with registered outputs
  // ---------------------------------------------------------------------------
  rx_state_e                state;
  logic [SPI_BIT_CNT_W-1:0] bit_cnt;
  // Only the first seven bits need storing; the eighth goes straight from
  // mosi_s into the output register.
  logic [6:0]               shift;
  rx_byte_t                 rx_q;
  logic                     byte_rdy_q;
`ifdef SPI_SLAVE_RX_ERR_EN
  logic                     err_q;
`endif

  // NOTE: every register here, including the shift register, has an explicit
  // reset value so outputs and internal state are defined from the first
  // cycle after reset release.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      rx_q       <= '0;
      byte_rdy_q <= 1'b0;
`ifdef SPI_SLAVE_RX_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      // Strobes default low; they are raised for a single cycle below.
      byte_rdy_q <= 1'b0;
`ifdef SPI_SLAVE_RX_ERR_EN
      err_q      <= 1'b0;
`endif

      unique case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (!cs_n_s) begin
            state <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          // Chip select release wins over a coincident SCLK edge; whatever
          // partial byte is in flight is dropped.
          if (cs_n_s) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
`ifdef SPI_SLAVE_RX_ERR_EN
            err_q   <= (bit_cnt != '0);
`endif
          end else if (sclk_rise) begin
            shift   <= {shift[5:0], mosi_s};
            // Wraps 7 -> 0 so back-to-back bytes need no gap.
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              rx_q.data  <= {shift, mosi_s};
              rx_q.dc    <= dc_s;
              byte_rdy_q <= 1'b1;
            end
          end
        end

        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.byte_rdy_out  = byte_rdy_q;
  assign bus.byte_data_out = rx_q.data;
  assign bus.dc_out        = rx_q.dc;
`ifdef SPI_SLAVE_RX_ERR_EN
  assign bus.err_out       = err_q;
`endif

endmodule : spi_slave_rx

// File: tb/tb_spi_slave_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_rx
//   Self-checking bench for spi_slave_rx. A host model drives mode-0 SPI
//   traffic; every byte expected to complete is pushed to a scoreboard queue
//   with the cycle of its 8th SCLK edge, and a monitor pops and compares on
//   each byte_rdy_out strobe (data, D/C, latency, strobe spacing).
//   Define SPI_SLAVE_RX_ERR_EN to also check err_out.
// -----------------------------------------------------------------------------
module tb_spi_slave_rx;
  import cube0414_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int LAT_MIN     = SYNC_STAGES + 1;
  localparam int LAT_MAX     = SYNC_STAGES + 3;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  always #5 clk_in = ~clk_in;

  spi_slave_rx_if bus ();

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   cyc        = 0;
  int   strobes    = 0;
  int   err_pulses = 0;
  logic rdy_prev   = 1'b0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk_in) begin
    if (rst_n_in) begin
      if (bus.byte_rdy_out) begin
        strobes++;
        check("strobe_not_back_to_back", {31'd0, rdy_prev}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe: got data %0h dc %0b expected no strobe",
                   bus.byte_data_out, bus.dc_out);
        end else begin
          exp_t e;
          int   lat;
          e   = sb.pop_front();
          lat = cyc - e.cyc;
          check("byte_data", {24'd0, bus.byte_data_out}, {24'd0, e.data});
          check("byte_dc", {31'd0, bus.dc_out}, {31'd0, e.dc});
          checks++;
          if (lat < LAT_MIN || lat > LAT_MAX) begin
            failures++;
            $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
          end
        end
      end
      rdy_prev = bus.byte_rdy_out;
`ifdef SPI_SLAVE_RX_ERR_EN
      if (bus.err_out) err_pulses++;
`endif
    end else begin
      rdy_prev = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Host model
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic cs_begin();
    bus.spi_sclk_in = 1'b0;
    bus.spi_cs_n_in = 1'b0;
    tick(3);
  endtask

  task automatic cs_end();
    bus.spi_sclk_in = 1'b0;
    tick(2);
    bus.spi_cs_n_in = 1'b1;
    tick(4);
  endtask

  // Sends nbits of data MSB first; dcm gives the D/C level per bit in the same
  // bit order. When push is set the expected byte is queued at the 8th edge.
  task automatic send_bits(input logic [7:0] data, input logic [7:0] dcm,
                           input int nbits, input int half, input bit push,
                           input logic [7:0] exp_data, input logic exp_dc);
    for (int k = 0; k < nbits; k++) begin
      bus.spi_sclk_in = 1'b0;
      bus.spi_mosi_in = data[7-k];
      bus.spi_dc_in   = dcm[7-k];
      tick(half);
      bus.spi_sclk_in = 1'b1;
      if (k == 7 && push) sb.push_back('{exp_data, exp_dc, cyc});
      tick(half);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb.size() > 0; i++) tick(1);
    check(name, sb.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Single-transaction vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [7:0] data;
    logic [7:0] dcm;
    int         half;
    logic [7:0] exp_data;
    logic       exp_dc;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: got no end of test expected finish within 2ms");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int s0;
    int e0;

    // clk/8 command byte, then assorted patterns; the last two vary D/C mid-byte.
    vecs[0] = '{"cmd_cc_clk8",     CUBE0414_ADDR_WR, 8'h00, 4, 8'hcc, 1'b0};
    vecs[1] = '{"ff_dc1",          8'hff,            8'hff, 2, 8'hff, 1'b1};
    vecs[2] = '{"zero_clk6",       8'h00,            8'h00, 3, 8'h00, 1'b0};
    vecs[3] = '{"msb_dc_last",     8'h80,            8'h01, 2, 8'h80, 1'b1};
    vecs[4] = '{"dc_high_end_low", 8'h69,            8'hfe, 2, 8'h69, 1'b0};
    vecs[5] = '{"dc_toggle",       8'h96,            8'h31, 2, 8'h96, 1'b1};

    bus.spi_sclk_in = 1'b0;
    bus.spi_mosi_in = 1'b0;
    bus.spi_cs_n_in = 1'b1;
    bus.spi_dc_in   = 1'b0;

    // Reset state
    #1;
    check("rst_byte_rdy", {31'd0, bus.byte_rdy_out}, 32'd0);
    check("rst_byte_data", {24'd0, bus.byte_data_out}, 32'd0);
    check("rst_dc", {31'd0, bus.dc_out}, 32'd0);
    check("rst_bit_cnt", {29'd0, dut.bit_cnt}, 32'd0);
`ifdef SPI_SLAVE_RX_ERR_EN
    check("rst_err", {31'd0, bus.err_out}, 32'd0);
`endif
    tick(3);
    rst_n_in = 1'b1;
    tick(6);

    // Table-driven single bytes
    for (int v = 0; v < 6; v++) begin
      s0 = strobes;
      cs_begin();
      send_bits(vecs[v].data, vecs[v].dcm, 8, vecs[v].half, 1'b1,
                vecs[v].exp_data, vecs[v].exp_dc);
      cs_end();
      drain({"drain_", vecs[v].name});
      check({"strobes_", vecs[v].name}, strobes - s0, 1);
    end

    // Output hold after the last table byte
    tick(10);
    check("hold_data", {24'd0, bus.byte_data_out}, 32'h96);
    check("hold_dc", {31'd0, bus.dc_out}, 32'd1);

    // Command 0xda then 192 data bytes in one CS assertion at clk/4
    s0 = strobes;
    cs_begin();
    send_bits(CUBE0414_DATA_WR, 8'h00, 8, 2, 1'b1, 8'hda, 1'b0);
    for (int i = 0; i < 192; i++) begin
      send_bits(8'(i), 8'hff, 8, 2, 1'b1, 8'(i), 1'b1);
    end
    cs_end();
    drain("drain_stream");
    check("strobes_stream", strobes - s0, 193);

    // Aborted partial byte, then a full byte
    s0 = strobes;
    e0 = err_pulses;
    cs_begin();
    send_bits(8'hff, 8'h00, 5, 2, 1'b0, 8'h00, 1'b0);
    tick(3);
    check("partial_bit_cnt", {29'd0, dut.bit_cnt}, 32'd5);
    cs_end();
`ifdef SPI_SLAVE_RX_ERR_EN
    check("abort_err_pulse", err_pulses - e0, 1);
`endif
    cs_begin();
    send_bits(8'h5a, 8'h00, 8, 2, 1'b1, 8'h5a, 1'b0);
    cs_end();
    drain("drain_abort");
    check("strobes_abort", strobes - s0, 1);

    // Reset pulsed after bit 4, then a fresh transaction
    s0 = strobes;
    cs_begin();
    send_bits(8'hab, 8'h00, 4, 2, 1'b0, 8'h00, 1'b0);
    tick(3);
    rst_n_in = 1'b0;
    #1;
    check("midrst_byte_rdy", {31'd0, bus.byte_rdy_out}, 32'd0);
    check("midrst_byte_data", {24'd0, bus.byte_data_out}, 32'd0);
    check("midrst_dc", {31'd0, bus.dc_out}, 32'd0);
    check("midrst_bit_cnt", {29'd0, dut.bit_cnt}, 32'd0);
    bus.spi_sclk_in = 1'b0;
    tick(3);
    rst_n_in = 1'b1;
    tick(3);
    bus.spi_cs_n_in = 1'b1;
    tick(4);
    cs_begin();
    send_bits(8'h3c, 8'h00, 8, 2, 1'b1, 8'h3c, 1'b0);
    cs_end();
    drain("drain_after_reset");
    check("strobes_after_reset", strobes - s0, 1);

    // CS_n rises together with the 8th SCLK edge: the edge must be ignored
    s0 = strobes;
    e0 = err_pulses;
    cs_begin();
    send_bits(8'hc3, 8'h00, 7, 2, 1'b0, 8'h00, 1'b0);
    bus.spi_sclk_in = 1'b0;
    bus.spi_mosi_in = 1'b1;
    tick(2);
    bus.spi_sclk_in = 1'b1;
    bus.spi_cs_n_in = 1'b1;
    tick(SYNC_STAGES + 4);
    check("coinc_bit_cnt", {29'd0, dut.bit_cnt}, 32'd0);
    bus.spi_sclk_in = 1'b0;
    tick(6);
    check("coinc_no_strobe", strobes - s0, 0);
`ifdef SPI_SLAVE_RX_ERR_EN
    check("coinc_err_pulse", err_pulses - e0, 1);
`endif

    // Totals
    check("scoreboard_empty", sb.size(), 0);
    check("total_strobes", strobes, 201);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spi_slave_rx
